// File: rtl/nln_prefetcher_if.sv
// Miss request / lookup response channel of the next-line prefetcher.
// The master side is the L1 miss source, the slave side is the prefetch buffer.
interface nln_prefetcher_if #(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 3
);
    logic              miss_valid;
    logic [ADDR_W-1:0] miss_addr;
    logic              miss_ready;
    logic              resp_valid;
    logic              resp_hit;
    logic [IDX_W-1:0]  resp_idx;

    modport master (
        output miss_valid, miss_addr,
        input  miss_ready, resp_valid, resp_hit, resp_idx
    );

    modport slave (
        input  miss_valid, miss_addr,
        output miss_ready, resp_valid, resp_hit, resp_idx
    );
endinterface

// File: rtl/nln_prefetcher.sv
// Next-N-line prefetch buffer: MRU-ordered line store, looked up on L1 misses,
// refilled with the DEGREE sequential lines following each missing line.
module nln_prefetcher #(
    parameter int ADDR_W      = 32,
    parameter int BLOCK_BYTES = 16,
    parameter int DEPTH       = 8,
    parameter int DEGREE      = 2,
    parameter int PF_ON_HIT   = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    nln_prefetcher_if.slave    bus,
    output logic [31:0]        hit_cnt,
    output logic [31:0]        miss_cnt
);
    localparam int OFF = $clog2(BLOCK_BYTES);
    localparam int LW  = ADDR_W - OFF;
    localparam int IW  = $clog2(DEPTH);
    localparam int KW  = $clog2(DEGREE + 1);

    typedef enum logic [1:0] {IDLE, LOOKUP, PROMOTE, FILL} state_t;

    state_t          state;
    logic [LW-1:0]   req_line;
    logic [KW-1:0]   k;
    logic [DEPTH-1:0] valid_q;
    logic [LW-1:0]   line_q [DEPTH];

    logic            lk_hit;
    logic [IW-1:0]   lk_idx;
    logic [LW-1:0]   cand;
    logic            cand_hit;
    logic            unused_off;

    assign unused_off    = ^bus.miss_addr[OFF-1:0];
    assign bus.miss_ready = (state == IDLE);

    // Lowest matching index wins on lookup; candidate line is req_line + k modulo 2^LW.
    always_comb begin
        lk_hit   = 1'b0;
        lk_idx   = '0;
        cand     = req_line + LW'(k);
        cand_hit = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!lk_hit && valid_q[i] && line_q[i] == req_line) begin
                lk_hit = 1'b1;
                lk_idx = IW'(i);
            end
            if (valid_q[i] && line_q[i] == cand) begin
                cand_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            req_line       <= '0;
            k              <= '0;
            valid_q        <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_hit   <= 1'b0;
            bus.resp_idx   <= '0;
            hit_cnt        <= '0;
            miss_cnt       <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                line_q[i] <= '0;
            end
        end else begin
            bus.resp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.miss_valid) begin
                        req_line <= bus.miss_addr[ADDR_W-1:OFF];
                        state    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    bus.resp_valid <= 1'b1;
                    bus.resp_hit   <= lk_hit;
                    bus.resp_idx   <= lk_idx;
                    if (lk_hit) begin
                        if (hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
                        state <= PROMOTE;
                    end else begin
                        if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
                        k     <= KW'(1);
                        state <= FILL;
                    end
                end
                PROMOTE: begin
                    // resp_idx still holds the hit position registered in LOOKUP.
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        if (IW'(i) <= bus.resp_idx) begin
                            line_q[i]  <= line_q[i-1];
                            valid_q[i] <= valid_q[i-1];
                        end
                    end
                    line_q[0]  <= line_q[bus.resp_idx];
                    valid_q[0] <= valid_q[bus.resp_idx];
                    if (PF_ON_HIT != 0) begin
                        k     <= KW'(1);
                        state <= FILL;
                    end else begin
                        state <= IDLE;
                    end
                end
                FILL: begin
                    if (!cand_hit) begin
                        for (int unsigned i = 1; i < DEPTH; i++) begin
                            line_q[i] <= line_q[i-1];
                        end
                        line_q[0] <= cand;
                        valid_q   <= {valid_q[DEPTH-2:0], 1'b1};
                    end
                    if (k == KW'(DEGREE)) begin
                        state <= IDLE;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
            endcase
            if (flush) begin
                valid_q <= '0;
                state   <= IDLE;
            end
        end
    end
endmodule
